regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered writeback entries (power of two, 2..8).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: wb_valid  input  1  writeback request valid.
REQ-005 Port: wb_ready  output  1  request accepted on a clk edge where wb_valid && wb_ready.
REQ-006 Port: wb_reg  input  5  destination register index.
REQ-007 Port: wb_data  input  `WORD  destination value.
REQ-008 Port: drain_en  input  1  register-file write port available this cycle.
REQ-009 Port: flush  input  1  discard all queued, not-yet-issued entries.
REQ-010 Port: write_register  output  5  register-file write address (registered).
REQ-011 Port: write_data  output  `WORD  register-file write data (registered).
REQ-012 Port: reg_write  output  1  register-file write enable (registered), one cycle per entry.
REQ-013 Port: fwd_reg  input  5  forwarding lookup index.
REQ-014 Port: fwd_hit  output  1  lookup matches a pending write (combinational).
REQ-015 Port: fwd_data  output  `WORD  value of the youngest matching pending write.
REQ-016 Port: pending  output  4  occupied queue entries, 0..DEPTH.

Function
REQ-017 The block SHALL hold accepted writes in a FIFO of DEPTH entries and issue them in acceptance order.
REQ-018 wb_ready SHALL be 1 iff pending < DEPTH and flush == 0; no bypass when full.
REQ-019 A request with wb_reg == 31 (XZR) SHALL be accepted but never enqueued or issued.
REQ-020 Each edge with drain_en == 1 SHALL load the oldest entry into write_register/write_data, set reg_write = 1, and pop it; with drain_en == 0 or nothing to issue, reg_write SHALL be 0 next cycle and write_register/write_data SHALL hold.
REQ-021 With the queue empty, a request accepted on edge k with drain_en == 1 SHALL bypass the queue: reg_write = 1 during the cycle after edge k (latency 1).
REQ-022 Simultaneous accept and issue in one edge SHALL leave pending unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 States: IDLE (pending == 0) and DRAIN (pending > 0); IDLE->DRAIN on accept without same-edge bypass; DRAIN->IDLE when the last entry issues with no accept, or on flush.
REQ-024 flush == 1 SHALL empty the queue on that edge, take priority over accept and issue (wb_ready = 0, reg_write = 0 next cycle); an entry already on the write port completes.
REQ-025 Sustained throughput with drain_en held 1 SHALL be one write per cycle.

Reset
REQ-026 rst_n low SHALL immediately force pending = 0, state IDLE, reg_write = 0, write_register = 0, write_data = 0, fwd_hit = 0, fwd_data = 0, pointers = 0.
REQ-027 Reset mid-operation SHALL discard all queued entries; none issue after rst_n rises.
REQ-028 wb_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro FORWARD_EN: when defined, fwd_hit/fwd_data SHALL search all queued entries plus the write-port register while reg_write == 1, returning the youngest match; fwd_reg == 31 SHALL never hit.
REQ-030 Without FORWARD_EN, fwd_hit and fwd_data SHALL be constant 0 and no comparison logic SHALL exist.

Verification
REQ-031 Empty queue, drain_en=1, accept X5=0x1234 -> next cycle reg_write=1, write_register=5, write_data=0x1234; following cycle reg_write=0.
REQ-032 drain_en=0, accept X1..X4 (DEPTH=4) -> pending=4, wb_ready=0; fifth request stalls; drain_en=1 -> X1,X2,X3,X4 issue on 4 consecutive cycles.
REQ-033 Accept X31=0xFFFF with drain_en=1 -> wb_ready=1, reg_write stays 0, pending stays 0.
REQ-034 FORWARD_EN, drain_en=0, queue X7=0xA then X7=0xB, fwd_reg=7 -> fwd_hit=1, fwd_data=0xB; fwd_reg=8 -> fwd_hit=0.
REQ-035 Queue 3 entries, assert flush for one edge -> pending=0, reg_write=0 next cycle, wb_ready=1 after flush drops.
REQ-036 Queue 2 entries, pull rst_n low mid-cycle -> reg_write=0 and pending=0 immediately, no writes after release.

Source files
------------

// File: rtl/regfile_writer_if.sv
// rtl/regfile_writer_if.sv - writeback request, register-file write port and forwarding lookup bundle
`ifndef WORD
`define WORD 32
`endif

interface regfile_writer_if;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_reg;
  logic [`WORD-1:0]  wb_data;
  logic              drain_en;
  logic              flush;
  logic [4:0]        write_register;
  logic [`WORD-1:0]  write_data;
  logic              reg_write;
  logic [4:0]        fwd_reg;
  logic              fwd_hit;
  logic [`WORD-1:0]  fwd_data;
  logic [3:0]        pending;

  modport master (
    output wb_valid, wb_reg, wb_data, drain_en, flush, fwd_reg,
    input  wb_ready, write_register, write_data, reg_write, fwd_hit, fwd_data, pending
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, drain_en, flush, fwd_reg,
    output wb_ready, write_register, write_data, reg_write, fwd_hit, fwd_data, pending
  );
endinterface

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - in-order writeback FIFO feeding one register-file write port
// Optional youngest-match forwarding lookup enabled by defining FORWARD_EN.
`ifndef WORD
`define WORD 32
`endif

module regfile_writer #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  regfile_writer_if.slave  bus
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0]        count_q, count_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [`WORD-1:0]  wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [4:0]        mem_reg  [DEPTH];
  logic [`WORD-1:0]  mem_data [DEPTH];
  logic              accept, enq, push, pop;

  assign bus.wb_ready       = (count_q < DEPTH_C) && !bus.flush;
  assign accept             = bus.wb_valid && bus.wb_ready;
  // XZR writes are acknowledged but have no architectural effect
  assign enq                = accept && (bus.wb_reg != 5'd31);
  assign bus.write_register = wreg_q;
  assign bus.write_data     = wdata_q;
  assign bus.reg_write      = rw_q;
  assign bus.pending        = count_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    rw_d     = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (bus.flush) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (bus.drain_en && state_q == DRAIN) begin
        wreg_d   = mem_reg[rd_ptr_q];
        wdata_d  = mem_data[rd_ptr_q];
        rw_d     = 1'b1;
        pop      = 1'b1;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (bus.drain_en && enq) begin
        // empty queue: the incoming request goes straight to the write port
        wreg_d  = bus.wb_reg;
        wdata_d = bus.wb_data;
        rw_d    = 1'b1;
      end
      if (enq && !(bus.drain_en && state_q == IDLE)) begin
        push     = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + 4'(push) - 4'(pop);
      state_d = (count_d != 4'd0) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_q]  <= bus.wb_reg;
      mem_data[wr_ptr_q] <= bus.wb_data;
    end
  end

`ifdef FORWARD_EN
  logic             hit;
  logic [`WORD-1:0] hdata;
  logic [PW-1:0]    idx;

  // scan oldest to youngest so the last match wins
  always_comb begin
    hit   = 1'b0;
    hdata = '0;
    idx   = '0;
    if (rw_q && wreg_q == bus.fwd_reg) begin
      hit   = 1'b1;
      hdata = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (4'(i) < count_q && mem_reg[idx] == bus.fwd_reg) begin
        hit   = 1'b1;
        hdata = mem_data[idx];
      end
    end
    if (bus.fwd_reg == 5'd31) begin
      hit   = 1'b0;
      hdata = '0;
    end
  end

  assign bus.fwd_hit  = hit;
  assign bus.fwd_data = hdata;
`else
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - vector table, corner sequences and randomized queue-model check of regfile_writer
module tb_regfile_writer;

  localparam int DEPTH = 4;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_writer_if bus();

  regfile_writer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
    logic        dr;
    logic        fl;
    logic        e_rdy;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic dr, input logic fl, input logic [4:0] fr);
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = d;
    bus.drain_en = dr;
    bus.flush    = fl;
    bus.fwd_reg  = fr;
  endtask

  function automatic logic model_ready();
    return (m_q.size() < DEPTH) && !bus.flush;
  endfunction

  // forwarding result from the spec rule: youngest pending write to the register
  task automatic model_fwd(input logic [4:0] fr, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (FWD && fr != 5'd31) begin
      if (m_rw && m_wreg == fr) begin hit = 1'b1; data = m_wdata; end
      foreach (m_q[i]) if (m_q[i].r == fr) begin hit = 1'b1; data = m_q[i].d; end
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (bus.flush) begin
      m_q.delete();
      m_rw = 1'b0;
    end else begin
      if (bus.wb_valid && m_q.size() < DEPTH && bus.wb_reg != 5'd31)
        m_q.push_back('{r: bus.wb_reg, d: bus.wb_data});
      if (bus.drain_en && m_q.size() > 0) begin
        e       = m_q.pop_front();
        m_rw    = 1'b1;
        m_wreg  = e.r;
        m_wdata = e.d;
      end else begin
        m_rw = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    m_q.delete();
    m_rw    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic step_plain(input logic v, input logic [4:0] r, input logic [31:0] d, input logic dr);
    drive(v, r, d, dr, 1'b0, 5'd0);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        fh;
    logic [31:0] fd;
    checks = 0;
    errors = 0;

    tbl[0]  = '{1'b1, 5'd5,  32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 4'd0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 4'd0};
    tbl[2]  = '{1'b1, 5'd31, 32'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 4'd0};
    tbl[3]  = '{1'b1, 5'd1,  32'h11,   1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 4'd1};
    tbl[4]  = '{1'b1, 5'd2,  32'h22,   1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 4'd2};
    tbl[5]  = '{1'b1, 5'd3,  32'h33,   1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 4'd3};
    tbl[6]  = '{1'b1, 5'd4,  32'h44,   1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 4'd4};
    tbl[7]  = '{1'b1, 5'd9,  32'h99,   1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 4'd4};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11,   4'd3};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22,   4'd2};
    tbl[10] = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33,   4'd1};
    tbl[11] = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44,   4'd0};
    tbl[12] = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44,   4'd0};
    tbl[13] = '{1'b1, 5'd6,  32'h66,   1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44,   4'd1};
    tbl[14] = '{1'b1, 5'd7,  32'h77,   1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44,   4'd2};
    tbl[15] = '{1'b1, 5'd8,  32'h88,   1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44,   4'd3};
    tbl[16] = '{1'b1, 5'd9,  32'h99,   1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h44,   4'd0};
    tbl[17] = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44,   4'd0};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    #12;
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_write_register", bus.write_register, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_fwd_hit", bus.fwd_hit, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", bus.wb_ready, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].dr, tbl[i].fl, 5'd0);
      #1;
      chk($sformatf("tbl%0d_wb_ready", i), bus.wb_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_reg_write", i), bus.reg_write, tbl[i].e_rw);
      chk($sformatf("tbl%0d_write_register", i), bus.write_register, tbl[i].e_wr);
      chk($sformatf("tbl%0d_write_data", i), bus.write_data, tbl[i].e_wd);
      chk($sformatf("tbl%0d_pending", i), bus.pending, tbl[i].e_pend);
    end

    // forwarding: two queued writes to X7, the younger must win
    do_reset();
    step_plain(1'b1, 5'd7, 32'hA, 1'b0);
    step_plain(1'b1, 5'd7, 32'hB, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd7);
    #1;
    chk("fwd7_hit", bus.fwd_hit, FWD ? 64'd1 : 64'd0);
    chk("fwd7_data", bus.fwd_data, FWD ? 64'hB : 64'd0);
    bus.fwd_reg = 5'd8;
    #1;
    chk("fwd8_hit", bus.fwd_hit, 0);
    chk("fwd8_data", bus.fwd_data, 0);

    // reset pulled while an entry is on the write port and one is queued
    do_reset();
    step_plain(1'b1, 5'd2, 32'h22, 1'b0);
    step_plain(1'b1, 5'd3, 32'h33, 1'b0);
    step_plain(1'b0, 5'd0, 32'h0, 1'b1);
    chk("pre_rst_reg_write", bus.reg_write, 1);
    chk("pre_rst_pending", bus.pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_reg_write", bus.reg_write, 0);
    chk("midrst_pending", bus.pending, 0);
    chk("midrst_write_register", bus.write_register, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_q.delete();
    m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      step_plain(1'b0, 5'd0, 32'h0, 1'b1);
      chk($sformatf("postrst%0d_reg_write", i), bus.reg_write, 0);
      chk($sformatf("postrst%0d_pending", i), bus.pending, 0);
    end

    // randomized traffic against the queue model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r, fr;
      r  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      fr = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 8));
      drive($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 9) < 5,
            $urandom_range(0, 29) == 0, fr);
      #1;
      chk("rnd_wb_ready", bus.wb_ready, model_ready());
      model_fwd(fr, fh, fd);
      chk("rnd_fwd_hit", bus.fwd_hit, fh);
      chk("rnd_fwd_data", bus.fwd_data, fd);
      model_edge();
      @(posedge clk);
      #1;
      chk("rnd_reg_write", bus.reg_write, m_rw);
      chk("rnd_write_register", bus.write_register, m_wreg);
      chk("rnd_write_data", bus.write_data, m_wdata);
      chk("rnd_pending", bus.pending, 4'(m_q.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
